// File: rtl/imm_encoder.sv
// Encodes a 16-bit signed constant into 8-bit immediate beats.
// A value that fits goes out as one IMM beat; other values go out as LUI then ORI, or saturate.
module imm_encoder #(
    parameter int unsigned ALLOW_SPLIT = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_upper,
    output logic [3:0]       out_lower,
    output logic [1:0]       out_kind,
    output logic             out_sat,
    output logic [CNT_W-1:0] split_count
);

    localparam int unsigned VAL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        HI    = 2'd2,
        LO    = 2'd3
    } state_t;

    localparam logic [1:0] KIND_IMM = 2'b00;
    localparam logic [1:0] KIND_LUI = 2'b01;
    localparam logic [1:0] KIND_ORI = 2'b10;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic [CNT_W-1:0]   split_count_q, split_count_d;
    logic               out_valid_q, out_valid_d;
    logic [3:0]         out_upper_q, out_upper_d;
    logic [3:0]         out_lower_q, out_lower_d;
    logic [1:0]         out_kind_q, out_kind_d;
    logic               out_sat_q, out_sat_d;

    logic               accept;
    logic               in_fits;
    logic               held_fits;
    logic [7:0]         imm_byte;

    assign in_ready  = (state_q == IDLE) |
                       (((state_q == SHORT) | (state_q == LO)) & out_ready);
    assign accept    = in_valid & in_ready;
    assign in_fits   = (&in_value[15:7]) | ~(|in_value[15:7]);
    assign held_fits = (&value_d[15:7]) | ~(|value_d[15:7]);

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            value_q       <= '0;
            split_count_q <= '0;
            out_valid_q   <= 1'b0;
            out_upper_q   <= '0;
            out_lower_q   <= '0;
            out_kind_q    <= KIND_IMM;
            out_sat_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            split_count_q <= split_count_d;
            out_valid_q   <= out_valid_d;
            out_upper_q   <= out_upper_d;
            out_lower_q   <= out_lower_d;
            out_kind_q    <= out_kind_d;
            out_sat_q     <= out_sat_d;
        end
    end

    // Next state; an accepted value may replace a final beat on the same edge
    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        split_count_d = split_count_q;
        case (state_q)
            HI: begin
                if (out_ready) begin
                    state_d       = LO;
                    split_count_d = split_count_q + CNT_W'(1);
                end
            end
            SHORT, LO: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            value_d = in_value;
            state_d = (in_fits || (ALLOW_SPLIT == 0)) ? SHORT : HI;
        end
    end

    // Output beat contents for the state being entered
    always_comb begin
        out_valid_d = 1'b0;
        out_upper_d = '0;
        out_lower_d = '0;
        out_kind_d  = KIND_IMM;
        out_sat_d   = 1'b0;
        imm_byte    = value_d[7:0];
        case (state_d)
            SHORT: begin
                out_valid_d = 1'b1;
                if (!held_fits) begin
                    imm_byte  = value_d[15] ? 8'h80 : 8'h7F;
                    out_sat_d = 1'b1;
                end
            end
            HI: begin
                out_valid_d = 1'b1;
                out_kind_d  = KIND_LUI;
                imm_byte    = value_d[15:8];
            end
            LO: begin
                out_valid_d = 1'b1;
                out_kind_d  = KIND_ORI;
            end
            default: begin
                imm_byte = '0;
            end
        endcase
        out_upper_d = imm_byte[7:4];
        out_lower_d = imm_byte[3:0];
    end

    assign out_valid   = out_valid_q;
    assign out_upper   = out_upper_q;
    assign out_lower   = out_lower_q;
    assign out_kind    = out_kind_q;
    assign out_sat     = out_sat_q;
    assign split_count = split_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: split instance (ALLOW_SPLIT=1) and saturating instance (ALLOW_SPLIT=0).
module tb_imm_encoder;

    logic        clock;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, out_sat;
    logic [15:0] in_value;
    logic [3:0]  out_upper, out_lower;
    logic [1:0]  out_kind;
    logic [7:0]  split_count;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
    logic [15:0] s_in_value;
    logic [3:0]  s_out_upper, s_out_lower;
    logic [1:0]  s_out_kind;
    logic [7:0]  s_split_count;

    int checks;
    int errors;

    imm_encoder #(.ALLOW_SPLIT(1), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_upper(out_upper), .out_lower(out_lower), .out_kind(out_kind),
        .out_sat(out_sat), .split_count(split_count)
    );

    imm_encoder #(.ALLOW_SPLIT(0), .CNT_W(8)) u_sat (
        .clock(clock), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_value(s_in_value),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_upper(s_out_upper), .out_lower(s_out_lower), .out_kind(s_out_kind),
        .out_sat(s_out_sat), .split_count(s_split_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packs {valid, kind, upper, lower, sat} so one comparison covers a whole beat
    function automatic logic [31:0] beat(input logic v, input logic [1:0] k,
                                         input logic [3:0] u, input logic [3:0] l,
                                         input logic s);
        return {20'd0, v, k, u, l, s};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_value    = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_value  = '0;
        s_out_ready = 1'b1;
        #23;
        reset = 1'b0;
        step();

        check_eq("reset_beat", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b0, 2'b00, 4'h0, 4'h0, 1'b0));
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        check_eq("reset_split_count", 32'(split_count), 32'd0);

        // 1: simple fitting value
        in_valid = 1'b1; in_value = 16'h0005;
        step();
        in_valid = 1'b0;
        check_eq("t1_beat", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h0, 4'h5, 1'b0));
        step();
        check_eq("t1_idle", 32'(out_valid), 32'd0);

        // 2: fit boundaries
        in_valid = 1'b1; in_value = 16'h007F;
        step();
        in_valid = 1'b0;
        check_eq("t2_007f", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h7, 4'hF, 1'b0));
        step();
        in_valid = 1'b1; in_value = 16'hFF80;
        step();
        in_valid = 1'b0;
        check_eq("t2_ff80", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h8, 4'h0, 1'b0));
        step();
        in_valid = 1'b1; in_value = 16'hFFF0;
        step();
        in_valid = 1'b0;
        check_eq("t2_fff0", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'hF, 4'h0, 1'b0));
        step();
        check_eq("t2_split_before", 32'(split_count), 32'd0);
        in_valid = 1'b1; in_value = 16'h0080;
        step();
        in_valid = 1'b0;
        check_eq("t2_0080_lui", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b01, 4'h0, 4'h0, 1'b0));
        step();
        check_eq("t2_0080_ori", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b10, 4'h8, 4'h0, 1'b0));
        check_eq("t2_split_count", 32'(split_count), 32'd1);
        step();
        check_eq("t2_idle", 32'(out_valid), 32'd0);

        // 3: back-pressure on LUI; input changes while not ready are ignored
        out_ready = 1'b0;
        in_valid = 1'b1; in_value = 16'h1234;
        step();
        in_value = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_lui_hold", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                     beat(1'b1, 2'b01, 4'h1, 4'h2, 1'b0));
            check_eq("t3_in_ready_hold", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("t3_in_ready_hi", 32'(in_ready), 32'd0);
        check_eq("t3_lui_last", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b01, 4'h1, 4'h2, 1'b0));
        step();
        check_eq("t3_ori", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b10, 4'h3, 4'h4, 1'b0));
        check_eq("t3_split_count", 32'(split_count), 32'd2);
        check_eq("t3_in_ready_lo", 32'(in_ready), 32'd1);
        step();
        check_eq("t3_idle", 32'(out_valid), 32'd0);

        // 4: back-to-back stream without bubbles
        in_valid = 1'b1; in_value = 16'h0001;
        step();
        check_eq("t4_beat1", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h0, 4'h1, 1'b0));
        check_eq("t4_ready1", 32'(in_ready), 32'd1);
        in_value = 16'h0002;
        step();
        check_eq("t4_beat2", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h0, 4'h2, 1'b0));
        in_value = 16'h0003;
        step();
        in_valid = 1'b0;
        check_eq("t4_beat3", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b00, 4'h0, 4'h3, 1'b0));
        step();
        check_eq("t4_idle", 32'(out_valid), 32'd0);

        // 5: saturating instance
        s_in_valid = 1'b1; s_in_value = 16'h0200;
        step();
        s_in_valid = 1'b0;
        check_eq("t5_pos_sat", beat(s_out_valid, s_out_kind, s_out_upper, s_out_lower, s_out_sat),
                 beat(1'b1, 2'b00, 4'h7, 4'hF, 1'b1));
        step();
        s_in_valid = 1'b1; s_in_value = 16'hFE00;
        step();
        s_in_valid = 1'b0;
        check_eq("t5_neg_sat", beat(s_out_valid, s_out_kind, s_out_upper, s_out_lower, s_out_sat),
                 beat(1'b1, 2'b00, 4'h8, 4'h0, 1'b1));
        step();
        check_eq("t5_idle", 32'(s_out_valid), 32'd0);
        check_eq("t5_split_count", 32'(s_split_count), 32'd0);

        // 6: reset drops a pending ORI beat
        in_valid = 1'b1; in_value = 16'hABCD;
        step();
        in_valid = 1'b0;
        check_eq("t6_lui", beat(out_valid, out_kind, out_upper, out_lower, out_sat),
                 beat(1'b1, 2'b01, 4'hA, 4'hB, 1'b0));
        step();
        check_eq("t6_split_before", 32'(split_count), 32'd3);
        reset = 1'b1;
        #2;
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_split", 32'(split_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        check_eq("t6_post_valid", 32'(out_valid), 32'd0);
        check_eq("t6_post_ready", 32'(in_ready), 32'd1);
        check_eq("t6_post_split", 32'(split_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
